mccu_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit-register / 32-bit-instruction MIPS core.

---
 rtl/mccu_pkg.sv | 66 ++++++
 rtl/mccu_decode.sv | 52 +++++
 rtl/mccu_fsm.sv | 186 ++++++++++++++++++
 tb/tb_mccu_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mccu_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// function codes, instruction classes and datapath select codes.
package mccu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_R, C_JR, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
    } iclass_t;

    // Longest tolerated memory stall before the bus error trips.
    localparam logic [3:0] WAIT_MAX = 4'd15;
    // Link register number; consumed by the datapath destination mux when jal=1.
    localparam logic [3:0] LINK_REG = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] PCSRC_ALU = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_QA  = 2'd2;
    localparam logic [1:0] PCSRC_JMP = 2'd3;

    localparam logic [1:0] SRCB_QB    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction decode: op/func -> class and per-class ALU controls.
// Unrecognised encodings decode to C_NOP.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output iclass_t    o_cls,
    output logic [3:0] o_aluc,
    output logic       o_sext,
    output logic       o_shift,
    output logic       o_regrt
);

    // Classify the instruction and pick its ALU operation.
    always_comb begin
        o_cls   = C_NOP;
        o_aluc  = ALUC_ADD;
        o_sext  = 1'b0;
        o_shift = 1'b0;
        o_regrt = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_func)
                    F_ADD: o_cls = C_R;
                    F_SUB: begin o_cls = C_R; o_aluc = ALUC_SUB; end
                    F_AND: begin o_cls = C_R; o_aluc = ALUC_AND; end
                    F_OR:  begin o_cls = C_R; o_aluc = ALUC_OR;  end
                    F_XOR: begin o_cls = C_R; o_aluc = ALUC_XOR; end
                    F_SLL: begin o_cls = C_R; o_aluc = ALUC_SLL; o_shift = 1'b1; end
                    F_SRL: begin o_cls = C_R; o_aluc = ALUC_SRL; o_shift = 1'b1; end
                    F_SRA: begin o_cls = C_R; o_aluc = ALUC_SRA; o_shift = 1'b1; end
                    F_JR:  o_cls = C_JR;
                    default: o_cls = C_NOP;
                endcase
            end
            OP_ADDI: begin o_cls = C_IALU; o_sext = 1'b1; o_regrt = 1'b1; end
            OP_ANDI: begin o_cls = C_IALU; o_aluc = ALUC_AND; o_regrt = 1'b1; end
            OP_ORI:  begin o_cls = C_IALU; o_aluc = ALUC_OR;  o_regrt = 1'b1; end
            OP_XORI: begin o_cls = C_IALU; o_aluc = ALUC_XOR; o_regrt = 1'b1; end
            OP_LUI:  begin o_cls = C_IALU; o_aluc = ALUC_LUI; o_regrt = 1'b1; end
            OP_LW:   begin o_cls = C_LW;   o_sext = 1'b1; o_regrt = 1'b1; end
            OP_SW:   begin o_cls = C_SW;   o_sext = 1'b1; end
            OP_BEQ:  begin o_cls = C_BEQ;  o_sext = 1'b1; o_aluc = ALUC_SUB; end
            OP_BNE:  begin o_cls = C_BNE;  o_sext = 1'b1; o_aluc = ALUC_SUB; end
            OP_J:    o_cls = C_J;
            OP_JAL:  o_cls = C_JAL;
            default: o_cls = C_NOP;
        endcase
    end

endmodule

// File: rtl/mccu_fsm.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer with a shared memory
// port, a memory stall watchdog and a sticky bus-error state.
// Memory handshake: mem_req is held high in IF/MEM; the access completes on the
// rising edge where mem_rdy=1, and mem_rdy in any other state is ignored.
module mccu_fsm
    import mccu_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       iord,
    output logic       wmem,
    output logic       wir,
    output logic       wpc,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsrc,
    output logic [2:0] state,
    output logic       err
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    logic [3:0] w_wait_inc;
    logic       w_timeout;
    logic       w_stalling;

    iclass_t    w_cls;
    logic [3:0] w_aluc;
    logic       w_sext;
    logic       w_shift;
    logic       w_regrt;

    // Ungated control values; forced to zero below while clrn is low.
    logic       w_mem_req, w_iord, w_wmem, w_wir, w_wpc, w_wreg, w_regrt_o;
    logic       w_m2reg, w_jal, w_sext_o, w_shift_o, w_alusrca, w_err;
    logic [1:0] w_alusrcb, w_pcsrc;
    logic [3:0] w_aluc_o;

    mccu_decode u_decode (
        .i_op    (op),
        .i_func  (func),
        .o_cls   (w_cls),
        .o_aluc  (w_aluc),
        .o_sext  (w_sext),
        .o_shift (w_shift),
        .o_regrt (w_regrt)
    );

    assign w_stalling = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_rdy;
    assign w_wait_inc = r_wait + 4'd1;
    assign w_timeout  = w_stalling && (w_wait_inc == WAIT_MAX);

    // State register and stall counter; the counter only runs while a stall persists.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IF;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_stalling && (w_next == r_state)) ? w_wait_inc : 4'd0;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:  w_next = mem_rdy ? S_ID : (w_timeout ? S_ERR : S_IF);
            S_ID:  w_next = (w_cls == C_J || w_cls == C_JAL || w_cls == C_NOP) ? S_IF : S_EXE;
            S_EXE: begin
                case (w_cls)
                    C_R, C_IALU: w_next = S_WB;
                    C_LW, C_SW:  w_next = S_MEM;
                    default:     w_next = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_rdy)        w_next = (w_cls == C_LW) ? S_WB : S_IF;
                else if (w_timeout) w_next = S_ERR;
                else                w_next = S_MEM;
            end
            S_WB:  w_next = S_IF;
            S_ERR: w_next = S_ERR;
            default: w_next = S_IF;
        endcase
    end

    // Datapath controls as a function of state, decoded class and z.
    always_comb begin
        w_mem_req = 1'b0; w_iord  = 1'b0; w_wmem  = 1'b0; w_wir     = 1'b0;
        w_wpc     = 1'b0; w_wreg  = 1'b0; w_regrt_o = 1'b0; w_m2reg = 1'b0;
        w_jal     = 1'b0; w_sext_o = 1'b0; w_shift_o = 1'b0; w_alusrca = 1'b0;
        w_alusrcb = SRCB_QB; w_aluc_o = ALUC_ADD; w_pcsrc = PCSRC_ALU; w_err = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_req = 1'b1;
                w_alusrcb = SRCB_FOUR;
                w_wir     = mem_rdy;
                w_wpc     = mem_rdy;
            end
            S_ID: begin
                w_alusrcb = SRCB_IMMSH;
                if (w_cls == C_J || w_cls == C_JAL) begin
                    w_wpc   = 1'b1;
                    w_pcsrc = PCSRC_JMP;
                end
                if (w_cls == C_JAL) begin
                    w_wreg = 1'b1;
                    w_jal  = 1'b1;
                end
            end
            S_EXE: begin
                w_alusrca = 1'b1;
                case (w_cls)
                    C_R: begin
                        w_aluc_o  = w_aluc;
                        w_shift_o = w_shift;
                    end
                    C_JR: begin
                        w_wpc   = 1'b1;
                        w_pcsrc = PCSRC_QA;
                    end
                    C_IALU, C_LW, C_SW: begin
                        w_alusrcb = SRCB_IMM;
                        w_aluc_o  = w_aluc;
                        w_sext_o  = w_sext;
                    end
                    C_BEQ, C_BNE: begin
                        w_aluc_o = ALUC_SUB;
                        w_sext_o = 1'b1;
                        if ((w_cls == C_BEQ && z) || (w_cls == C_BNE && !z)) begin
                            w_wpc   = 1'b1;
                            w_pcsrc = PCSRC_BR;
                        end
                    end
                    default: w_alusrca = 1'b1;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_wmem    = (w_cls == C_SW);
            end
            S_WB: begin
                w_wreg    = 1'b1;
                w_regrt_o = w_regrt;
                w_m2reg   = (w_cls == C_LW);
            end
            S_ERR: w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
    end

    // Reset forces every output low immediately, including a pending request or write.
    assign mem_req = clrn & w_mem_req;
    assign iord    = clrn & w_iord;
    assign wmem    = clrn & w_wmem;
    assign wir     = clrn & w_wir;
    assign wpc     = clrn & w_wpc;
    assign wreg    = clrn & w_wreg;
    assign regrt   = clrn & w_regrt_o;
    assign m2reg   = clrn & w_m2reg;
    assign jal     = clrn & w_jal;
    assign sext    = clrn & w_sext_o;
    assign shift   = clrn & w_shift_o;
    assign alusrca = clrn & w_alusrca;
    assign alusrcb = clrn ? w_alusrcb : 2'd0;
    assign aluc    = clrn ? w_aluc_o  : 4'd0;
    assign pcsrc   = clrn ? w_pcsrc   : 2'd0;
    assign state   = clrn ? r_state   : 3'd0;
    assign err     = clrn & w_err;

endmodule

// File: tb/tb_mccu_fsm.sv
// Directed bench for mccu_fsm: each step pushes the expected control vector
// and compares it with the DUT outputs sampled on the falling clock edge.
module tb_mccu_fsm;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       z = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal;
    logic       sext, shift, alusrca, err;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluc;
    logic [2:0] state;

    logic [23:0] exp_q[$];
    int tests_run = 0;
    int fail_cnt  = 0;

    wire [23:0] obs = {mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal,
                       sext, shift, alusrca, alusrcb, aluc, pcsrc, state, err};

    mccu_fsm dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .iord(iord), .wmem(wmem), .wir(wir), .wpc(wpc),
        .wreg(wreg), .regrt(regrt), .m2reg(m2reg), .jal(jal), .sext(sext),
        .shift(shift), .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc),
        .pcsrc(pcsrc), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    // Expected output vector; any field not named is 0.
    function automatic logic [23:0] v(
        input logic mem_req_e = 1'b0, input logic iord_e = 1'b0,
        input logic wmem_e = 1'b0,    input logic wir_e = 1'b0,
        input logic wpc_e = 1'b0,     input logic wreg_e = 1'b0,
        input logic regrt_e = 1'b0,   input logic m2reg_e = 1'b0,
        input logic jal_e = 1'b0,     input logic sext_e = 1'b0,
        input logic shift_e = 1'b0,   input logic alusrca_e = 1'b0,
        input logic [1:0] alusrcb_e = 2'd0, input logic [3:0] aluc_e = 4'd0,
        input logic [1:0] pcsrc_e = 2'd0,   input logic [2:0] state_e = 3'd0,
        input logic err_e = 1'b0);
        return {mem_req_e, iord_e, wmem_e, wir_e, wpc_e, wreg_e, regrt_e, m2reg_e,
                jal_e, sext_e, shift_e, alusrca_e, alusrcb_e, aluc_e, pcsrc_e,
                state_e, err_e};
    endfunction

    function automatic logic [23:0] e_if(input logic rdy);
        return v(.mem_req_e(1'b1), .wir_e(rdy), .wpc_e(rdy), .alusrcb_e(2'd1), .state_e(3'd0));
    endfunction

    function automatic logic [23:0] e_id();
        return v(.alusrcb_e(2'd3), .state_e(3'd1));
    endfunction

    task automatic compare(input string tag);
        logic [23:0] ex;
        tests_run++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            ex = exp_q.pop_front();
            assert (obs === ex) else begin
                fail_cnt++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
            end
        end
    endtask

    // One clock cycle: expectation checked at the falling edge, then advance.
    task automatic step(input string tag, input logic [23:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [23:0] e);
        exp_q.push_back(e);
        #1;
        compare(tag);
    endtask

    initial begin
        // Reset state: all outputs low even with mem_rdy asserted.
        mem_rdy = 1'b1;
        #2;
        check_now("reset", v());
        @(posedge clk);
        #1;
        clrn = 1'b1;

        // add, no stalls: IF ID EXE WB
        op = 6'b000000; func = 6'b100000;
        step("add_if",  e_if(1'b1));
        step("add_id",  e_id());
        step("add_exe", v(.alusrca_e(1'b1), .state_e(3'd2)));
        step("add_wb",  v(.wreg_e(1'b1), .state_e(3'd4)));

        // sra: shift flag and aluc 1111
        op = 6'b000000; func = 6'b000011;
        step("sra_if",  e_if(1'b1));
        step("sra_id",  e_id());
        step("sra_exe", v(.alusrca_e(1'b1), .shift_e(1'b1), .aluc_e(4'b1111), .state_e(3'd2)));
        step("sra_wb",  v(.wreg_e(1'b1), .state_e(3'd4)));

        // lw with 3 stall cycles in MEM: 8 cycles total
        op = 6'b100011; func = $urandom_range(63, 0);
        step("lw_if",  e_if(1'b1));
        step("lw_id",  e_id());
        step("lw_exe", v(.alusrca_e(1'b1), .alusrcb_e(2'd2), .sext_e(1'b1), .state_e(3'd2)));
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw_mem_stall", v(.mem_req_e(1'b1), .iord_e(1'b1), .state_e(3'd3)));
        mem_rdy = 1'b1;
        step("lw_mem_done", v(.mem_req_e(1'b1), .iord_e(1'b1), .state_e(3'd3)));
        step("lw_wb", v(.wreg_e(1'b1), .regrt_e(1'b1), .m2reg_e(1'b1), .state_e(3'd4)));

        // ori: zero-extended immediate, or
        op = 6'b001101;
        step("ori_if",  e_if(1'b1));
        step("ori_id",  e_id());
        step("ori_exe", v(.alusrca_e(1'b1), .alusrcb_e(2'd2), .aluc_e(4'b0101), .state_e(3'd2)));
        step("ori_wb",  v(.wreg_e(1'b1), .regrt_e(1'b1), .state_e(3'd4)));

        // beq/bne taken and not taken
        op = 6'b000100; z = 1'b1;
        step("beq_t_if",  e_if(1'b1));
        step("beq_t_id",  e_id());
        step("beq_t_exe", v(.alusrca_e(1'b1), .sext_e(1'b1), .aluc_e(4'b0100),
                            .wpc_e(1'b1), .pcsrc_e(2'd1), .state_e(3'd2)));
        z = 1'b0;
        step("beq_n_if",  e_if(1'b1));
        step("beq_n_id",  e_id());
        step("beq_n_exe", v(.alusrca_e(1'b1), .sext_e(1'b1), .aluc_e(4'b0100), .state_e(3'd2)));
        op = 6'b000101; z = 1'b0;
        step("bne_t_if",  e_if(1'b1));
        step("bne_t_id",  e_id());
        step("bne_t_exe", v(.alusrca_e(1'b1), .sext_e(1'b1), .aluc_e(4'b0100),
                            .wpc_e(1'b1), .pcsrc_e(2'd1), .state_e(3'd2)));
        z = 1'b1;
        step("bne_n_if",  e_if(1'b1));
        step("bne_n_id",  e_id());
        step("bne_n_exe", v(.alusrca_e(1'b1), .sext_e(1'b1), .aluc_e(4'b0100), .state_e(3'd2)));

        // jal and j finish in ID
        op = 6'b000011;
        step("jal_if", e_if(1'b1));
        step("jal_id", v(.alusrcb_e(2'd3), .wpc_e(1'b1), .pcsrc_e(2'd3), .wreg_e(1'b1),
                         .jal_e(1'b1), .state_e(3'd1)));
        op = 6'b000010;
        step("j_if", e_if(1'b1));
        step("j_id", v(.alusrcb_e(2'd3), .wpc_e(1'b1), .pcsrc_e(2'd3), .state_e(3'd1)));

        // jr: EXE loads PC from qa
        op = 6'b000000; func = 6'b001000;
        step("jr_if",  e_if(1'b1));
        step("jr_id",  e_id());
        step("jr_exe", v(.alusrca_e(1'b1), .wpc_e(1'b1), .pcsrc_e(2'd2), .state_e(3'd2)));

        // illegal op behaves as a NOP and returns to IF after ID
        op = 6'b111111;
        step("ill_if", e_if(1'b1));
        step("ill_id", e_id());
        step("ill_back_if", e_if(1'b1));

        // sw stall in MEM, then asynchronous reset mid-access
        op = 6'b101011;
        step("sw_id",  e_id());
        step("sw_exe", v(.alusrca_e(1'b1), .alusrcb_e(2'd2), .sext_e(1'b1), .state_e(3'd2)));
        mem_rdy = 1'b0;
        step("sw_mem_stall0", v(.mem_req_e(1'b1), .iord_e(1'b1), .wmem_e(1'b1), .state_e(3'd3)));
        step("sw_mem_stall1", v(.mem_req_e(1'b1), .iord_e(1'b1), .wmem_e(1'b1), .state_e(3'd3)));
        #1;
        clrn = 1'b0;
        check_now("sw_reset_drop", v());
        @(posedge clk);
        #1;
        clrn = 1'b1;

        // fetch stalled forever: 15 stall cycles in IF, then ERR
        for (int i = 0; i < 15; i++)
            step("if_stall", e_if(1'b0));
        step("err_enter", v(.state_e(3'd7), .err_e(1'b1)));
        mem_rdy = 1'b1;
        step("err_sticky0", v(.state_e(3'd7), .err_e(1'b1)));
        step("err_sticky1", v(.state_e(3'd7), .err_e(1'b1)));
        clrn = 1'b0;
        check_now("err_reset", v());
        @(posedge clk);
        #1;
        clrn = 1'b1;
        step("after_err_if", e_if(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
